lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU in the single-issue core.
- Takes the ALU result as the effective address, plus rs2 as store data.
- Runs a valid/ready request to data memory, waits for the load response, then aligns and sign- or zero-extends the returned data for writeback.
- Stalls the core, holding the PC and instruction, while a memory access is outstanding.

---
 rtl/lsu_mem_stage_pkg.sv | 20 ++
 rtl/lsu_mem_stage_load_align.sv | 35 +++
 rtl/lsu_mem_stage.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage: RV32I width codes,
// FSM state encoding and the byte-strobe width.
package lsu_mem_stage_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int unsigned LSU_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the raw
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select then extension
    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
            LSU_BU:  o_data = {24'h0, w_byte};
            LSU_H:   o_data = {{16{w_half[15]}}, w_half};
            LSU_HU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit after the ALU: legality check, store formatting, a
// valid/ready request to data memory and registered, aligned load writeback.
// Stalls the core while an access is outstanding.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  stall,
    output logic                  ls_fault,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [LSU_STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data
);

    lsu_state_t            r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [LSU_STRB_W-1:0] r_wstrb;
    logic [2:0]            r_funct3;
    logic                  r_is_load;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_one_op;
    logic                  w_f3_ok;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_accept;
    logic [LSU_STRB_W-1:0] w_strb;
    logic [DATA_W-1:0]     w_wfmt;
    logic [DATA_W-1:0]     w_aligned;

    // Legality of the incoming access (only meaningful while IDLE)
    always_comb begin
        w_one_op = is_load ^ is_store;
        w_f3_ok  = 1'b0;
        case (funct3)
            LSU_B, LSU_H, LSU_W: w_f3_ok = 1'b1;
            LSU_BU, LSU_HU:      w_f3_ok = is_load;
            default:             w_f3_ok = 1'b0;
        endcase
        w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_illegal  = (is_load && is_store) || (w_one_op && (!w_f3_ok || w_misalign));
        ls_fault   = (r_state == ST_IDLE) && req_valid && w_illegal;
        w_accept   = (r_state == ST_IDLE) && req_valid && w_one_op && !w_illegal;
    end

    // Store byte enables and lane-replicated data, computed at accept time
    always_comb begin
        w_strb = '0;
        w_wfmt = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_strb = 4'b0001 << addr[1:0];
                w_wfmt = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_strb = 4'b0011 << {addr[1], 1'b0};
                w_wfmt = {2{wdata[15:0]}};
            end
            default: w_strb = '1;
        endcase
        if (is_load) begin
            w_strb = '0;
        end
    end

    load_align u_load_align (
        .i_word   (mem_rsp_data),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned)
    );

    // Access sequencer: capture, request handshake, response wait, writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_funct3  <= '0;
            r_is_load <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= addr;
                        r_wdata   <= w_wfmt;
                        r_wstrb   <= w_strb;
                        r_funct3  <= funct3;
                        r_is_load <= is_load;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= r_is_load ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rdata <= w_aligned;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs; stall covers the accept cycle combinationally so the core
    // holds the instruction from the very first cycle of the access
    always_comb begin
        stall         = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
        mem_req_valid = (r_state == ST_REQ);
        mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
        mem_we        = (r_state == ST_REQ) && !r_is_load;
        mem_wstrb     = (r_state == ST_REQ) ? r_wstrb : '0;
        mem_wdata     = r_wdata;
        rdata         = r_rdata;
        rdata_valid   = (r_state == ST_DONE) && r_is_load;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, ls_fault, rdata_valid;
    logic [31:0] rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .ls_fault(ls_fault), .rdata(rdata), .rdata_valid(rdata_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    // Runs one access with the given ready/response delays and reports what
    // was observed. Entered and left at 1 time unit after a rising edge.
    task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rsp,
                          input int rdy_dly, input int rsp_dly,
                          output int stall_cnt, output int cyc,
                          output logic [31:0] o_maddr, output logic o_we,
                          output logic [3:0] o_strb, output logic [31:0] o_wd,
                          output logic unstable, output logic [31:0] o_rdata,
                          output logic o_rv, output logic o_rv_after);
        int reqcnt = 0;
        int waitcnt = 0;
        logic hs = 1'b0;
        logic seen = 1'b0;
        logic done = 1'b0;
        req_valid = 1'b1; is_load = ld; is_store = !ld; funct3 = f3;
        addr = a; wdata = wd; mem_rsp_data = rsp;
        stall_cnt = 0; cyc = 0; unstable = 1'b0; o_rdata = '0; o_rv = 1'b0;
        o_maddr = '0; o_we = 1'b0; o_strb = '0; o_wd = '0;
        for (int i = 0; i < 64 && !done; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            #1;
            if (mem_req_valid) begin
                if (!seen) begin
                    o_maddr = mem_addr; o_we = mem_we; o_strb = mem_wstrb; o_wd = mem_wdata;
                    seen = 1'b1;
                end else if (o_maddr !== mem_addr || o_we !== mem_we ||
                             o_strb !== mem_wstrb || o_wd !== mem_wdata) begin
                    unstable = 1'b1;
                end
                mem_req_ready = (reqcnt >= rdy_dly);
                reqcnt++;
            end else if (hs && ld) begin
                mem_rsp_valid = (waitcnt >= rsp_dly);
                waitcnt++;
            end
            #1;
            if (stall) begin
                stall_cnt++;
            end else if (i > 0) begin
                done = 1'b1; o_rv = rdata_valid; o_rdata = rdata; cyc = i + 1;
            end
            if (mem_req_valid && mem_req_ready) hs = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        o_rv_after = rdata_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #2;
        n_tests++;
        if ({stall, ls_fault, rdata_valid, mem_req_valid, mem_we, mem_wstrb} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0", {stall, ls_fault, rdata_valid, mem_req_valid, mem_we, mem_wstrb});
        end
        n_tests++;
        if (rdata !== 32'h0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got rdata=%h addr=%h exp 0", rdata, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        int sc, cy; logic [31:0] ma, wdo, rd; logic we, un, rv, rva; logic [3:0] sb;
        run_op(1'b1, LSU_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (ma !== 32'h100 || we !== 1'b0 || sb !== 4'b0000) begin
            n_fail++; $display("FAIL lw_req got addr=%h we=%b strb=%b exp 100/0/0000", ma, we, sb);
        end
        n_tests++;
        if (sc !== 4 || cy !== 5) begin
            n_fail++; $display("FAIL lw_latency got stall=%0d cyc=%0d exp 4/5", sc, cy);
        end
        n_tests++;
        if (rd !== 32'hDEADBEEF || rv !== 1'b1 || rva !== 1'b0) begin
            n_fail++; $display("FAIL lw_data got %h rv=%b after=%b exp deadbeef/1/0", rd, rv, rva);
        end
        run_op(1'b1, LSU_B, 32'h103, 32'h0, 32'h80FF0000, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'hFFFFFF80 || rv !== 1'b1) begin
            n_fail++; $display("FAIL lb_data got %h rv=%b exp ffffff80/1", rd, rv);
        end
        n_tests++;
        if (sc !== 3 || cy !== 4 || ma !== 32'h100) begin
            n_fail++; $display("FAIL lb_min_latency got stall=%0d cyc=%0d addr=%h exp 3/4/100", sc, cy, ma);
        end
        run_op(1'b1, LSU_BU, 32'h103, 32'h0, 32'h80FF0000, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_data got %h exp 00000080", rd);
        end
        run_op(1'b1, LSU_B, 32'h101, 32'h0, 32'h00007F00, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'h0000007F) begin
            n_fail++; $display("FAIL lb_lane1 got %h exp 0000007f", rd);
        end
        run_op(1'b1, LSU_HU, 32'h100, 32'h0, 32'h1234F00D, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'h0000F00D) begin
            n_fail++; $display("FAIL lhu_data got %h exp 0000f00d", rd);
        end
        run_op(1'b1, LSU_H, 32'h102, 32'h0, 32'h80011234, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh_data got %h exp ffff8001", rd);
        end
    endtask

    task automatic test_stores();
        int sc, cy; logic [31:0] ma, wdo, rd; logic we, un, rv, rva; logic [3:0] sb;
        run_op(1'b0, LSU_H, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (ma !== 32'h200 || we !== 1'b1 || sb !== 4'b1100 || wdo !== 32'hABCDABCD) begin
            n_fail++; $display("FAIL sh_req got addr=%h we=%b strb=%b wd=%h exp 200/1/1100/abcdabcd", ma, we, sb, wdo);
        end
        n_tests++;
        if (sc !== 2 || cy !== 3 || rv !== 1'b0) begin
            n_fail++; $display("FAIL sh_latency got stall=%0d cyc=%0d rv=%b exp 2/3/0", sc, cy, rv);
        end
        n_tests++;
        if (rd !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL sh_rdata_hold got %h exp ffff8001", rd);
        end
        run_op(1'b0, LSU_B, 32'h201, 32'h000000A5, 32'h0, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (sb !== 4'b0010 || wdo !== 32'hA5A5A5A5 || ma !== 32'h200) begin
            n_fail++; $display("FAIL sb_req got strb=%b wd=%h addr=%h exp 0010/a5a5a5a5/200", sb, wdo, ma);
        end
        run_op(1'b0, LSU_W, 32'h300, 32'hCAFEF00D, 32'h0, 3, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (un !== 1'b0 || ma !== 32'h300 || sb !== 4'b1111 || wdo !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL sw_backpressure got unstable=%b addr=%h strb=%b wd=%h exp 0/300/1111/cafef00d", un, ma, sb, wdo);
        end
        n_tests++;
        if (sc !== 5 || cy !== 6 || rv !== 1'b0) begin
            n_fail++; $display("FAIL sw_ready_delay got stall=%0d cyc=%0d rv=%b exp 5/6/0", sc, cy, rv);
        end
    endtask

    task automatic test_faults();
        logic        t_ld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        t_st [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  t_f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110};
        logic [31:0] t_a  [5] = '{32'h101, 32'h203, 32'h100, 32'h100, 32'h100};
        for (int k = 0; k < 5; k++) begin
            int req_seen = 0;
            req_valid = 1'b1; is_load = t_ld[k]; is_store = t_st[k];
            funct3 = t_f3[k]; addr = t_a[k]; wdata = 32'h55AA55AA;
            #1;
            n_tests++;
            if (ls_fault !== 1'b1 || stall !== 1'b0) begin
                n_fail++; $display("FAIL fault_%0d got fault=%b stall=%b exp 1/0", k, ls_fault, stall);
            end
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #2;
                if (mem_req_valid !== 1'b0 || stall !== 1'b0) req_seen++;
            end
            n_tests++;
            if (req_seen !== 0) begin
                n_fail++; $display("FAIL fault_%0d_idle got %0d busy cycles exp 0", k, req_seen);
            end
            req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
            #1;
            n_tests++;
            if (ls_fault !== 1'b0) begin
                n_fail++; $display("FAIL fault_%0d_clear got %b exp 0", k, ls_fault);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (rdata !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL fault_rdata_hold got %h exp ffff8001", rdata);
        end
    endtask

    task automatic test_reset_mid();
        int sc, cy; logic [31:0] ma, wdo, rd; logic we, un, rv, rva; logic [3:0] sb;
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = LSU_W;
        addr = 32'h400; mem_req_ready = 1'b1; mem_rsp_data = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait got stall=%b reqv=%b exp 1/0", stall, mem_req_valid);
        end
        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; mem_req_ready = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0 || rdata !== 32'h0 || rdata_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got stall=%b reqv=%b rdata=%h rv=%b exp 0", stall, mem_req_valid, rdata, rdata_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_rsp got rdata=%h rv=%b stall=%b exp 0/0/0", rdata, rdata_valid, stall);
        end
        @(posedge clk); #1;
        run_op(1'b1, LSU_W, 32'h404, 32'h0, 32'h5A5A5A5A, 0, 0, sc, cy, ma, we, sb, wdo, un, rd, rv, rva);
        n_tests++;
        if (rd !== 32'h5A5A5A5A || sc !== 3 || ma !== 32'h404 || rv !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_lw got rd=%h stall=%0d addr=%h rv=%b exp 5a5a5a5a/3/404/1", rd, sc, ma, rv);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
